// File: rtl/tlb_alloc_ctrl_pkg.sv
// rtl/tlb_alloc_ctrl_pkg.sv - shared types and helpers for the TLB allocation controller
package tlb_alloc_ctrl_pkg;

  localparam int WAYS  = 16;
  localparam int WAY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MREQ  = 2'd1,
    ST_MWAIT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [WAY_W-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (oh[i]) idx = idx | WAY_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [WAYS-1:0] lowest_set(input logic [WAYS-1:0] v);
    return v & (~v + WAYS'(1));
  endfunction

endpackage

// File: rtl/plru_16.sv
// rtl/plru_16.sv - 16-way tree pseudo-LRU: victim select and recency update
module plru_16
  import tlb_alloc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hit_i,
  input  logic [WAYS-1:0] hit_sel_i,
  input  logic            wen_i,
  output logic [WAYS-1:0] victim_o
);

  // Heap-ordered node bits: node n has children 2n+1 / 2n+2; bit 0 points left.
  logic [WAYS-2:0]  tree_q, tree_d;
  logic [4:0]       node;
  logic [4:0]       leaf;
  logic [WAY_W-1:0] victim_idx;
  logic [WAY_W-1:0] acc;

  always_comb begin
    node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      node = {node[3:0], 1'b0} + 5'd1 + {4'b0, tree_q[node[3:0]]};
    end
    leaf       = node - 5'd15;
    victim_idx = leaf[WAY_W-1:0];
    victim_o   = '0;
    victim_o[victim_idx] = 1'b1;
  end

  // Touching a way flips every node on its path to point at the other subtree.
  always_comb begin
    tree_d = tree_q;
    acc    = hit_i ? onehot_to_idx(hit_sel_i) : victim_idx;
    if (hit_i || wen_i) begin
      tree_d[0]                        = ~acc[3];
      tree_d[4'd1 + {3'b0, acc[3]}]    = ~acc[2];
      tree_d[4'd3 + {2'b0, acc[3:2]}]  = ~acc[1];
      tree_d[4'd7 + {1'b0, acc[3:1]}]  = ~acc[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tree_q <= '0;
    else        tree_q <= tree_d;
  end

endmodule

// File: rtl/tlb_alloc_ctrl.sv
// rtl/tlb_alloc_ctrl.sv - fully-associative lookup/refill controller with victim allocation
module tlb_alloc_ctrl
  import tlb_alloc_ctrl_pkg::*;
#(
  parameter int TAG_W  = 27,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_data,
  output logic [WAY_W-1:0]  resp_way,
  output logic              ref_req_valid,
  input  logic              ref_req_ready,
  output logic [TAG_W-1:0]  ref_req_tag,
  input  logic              ref_resp_valid,
  input  logic              ref_resp_err,
  input  logic [DATA_W-1:0] ref_resp_data
);

  state_e              state_q;
  logic [WAYS-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]    tag_arr [WAYS];
  logic [DATA_W-1:0]   data_arr [WAYS];
  logic [TAG_W-1:0]    tag_q;
  logic                discard_q;
  logic                resp_hit_q, resp_err_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [WAY_W-1:0]    resp_way_q;

  logic [WAYS-1:0]     match, invalid_oh, plru_victim, victim_oh, plru_sel;
  logic [WAY_W-1:0]    victim_idx, hit_idx;
  logic                accept, hit_now, fill_ok, any_invalid, plru_hit, plru_wen;

  always_comb begin
    match = '0;
    for (int i = 0; i < WAYS; i++) begin
      match[i] = valid_q[i] && (tag_arr[i] == req_tag);
    end
  end

  assign accept      = (state_q == ST_IDLE) && req_valid && !flush;
  assign hit_now     = accept && (|match);
  assign hit_idx     = onehot_to_idx(match);
  // A flush arriving alongside the walker result also discards the fill.
  assign fill_ok     = (state_q == ST_MWAIT) && ref_resp_valid && !ref_resp_err
                       && !discard_q && !flush;
  assign any_invalid = ~&valid_q;
  assign invalid_oh  = lowest_set(~valid_q);
  assign victim_oh   = any_invalid ? invalid_oh : plru_victim;
  assign victim_idx  = onehot_to_idx(victim_oh);

  assign plru_hit = hit_now || (fill_ok && any_invalid);
  assign plru_sel = hit_now ? match : invalid_oh;
  assign plru_wen = fill_ok && !any_invalid;

  plru_16 u_plru (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_i     (plru_hit),
    .hit_sel_i (plru_sel),
    .wen_i     (plru_wen),
    .victim_o  (plru_victim)
  );

  always_comb begin
    valid_d = valid_q;
    if (flush)        valid_d = '0;
    else if (fill_ok) valid_d = valid_q | victim_oh;
  end

  always_ff @(posedge clk) begin
    if (fill_ok) begin
      tag_arr[victim_idx]  <= tag_q;
      data_arr[victim_idx] <= ref_resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      tag_q       <= '0;
      discard_q   <= 1'b0;
      resp_hit_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      resp_way_q  <= '0;
    end else begin
      valid_q <= valid_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q     <= req_tag;
            discard_q <= 1'b0;
            if (|match) begin
              resp_hit_q  <= 1'b1;
              resp_err_q  <= 1'b0;
              resp_data_q <= data_arr[hit_idx];
              resp_way_q  <= hit_idx;
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_MREQ;
            end
          end
        end
        ST_MREQ: begin
          if (flush)         discard_q <= 1'b1;
          if (ref_req_ready) state_q   <= ST_MWAIT;
        end
        ST_MWAIT: begin
          if (flush) discard_q <= 1'b1;
          if (ref_resp_valid) begin
            resp_hit_q  <= 1'b0;
            resp_err_q  <= ref_resp_err;
            resp_data_q <= ref_resp_err ? '0 : ref_resp_data;
            resp_way_q  <= ref_resp_err ? '0 : victim_idx;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !flush;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_hit      = resp_hit_q;
  assign resp_err      = resp_err_q;
  assign resp_data     = resp_data_q;
  assign resp_way      = resp_way_q;
  assign ref_req_valid = (state_q == ST_MREQ);
  assign ref_req_tag   = tag_q;

endmodule

// File: tb/tb_tlb_alloc_ctrl.sv
// tb/tb_tlb_alloc_ctrl.sv - self-checking bench for tlb_alloc_ctrl against a behavioural model
module tb_tlb_alloc_ctrl;

  localparam int TAG_W  = 27;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_hit;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;
  logic [3:0]        resp_way;
  logic              ref_req_valid;
  logic              ref_req_ready = 1'b0;
  logic [TAG_W-1:0]  ref_req_tag;
  logic              ref_resp_valid = 1'b0;
  logic              ref_resp_err = 1'b0;
  logic [DATA_W-1:0] ref_resp_data = '0;

  int checks = 0;
  int failures = 0;

  bit                m_valid [16];
  logic [TAG_W-1:0]  m_tag   [16];
  logic [DATA_W-1:0] m_data  [16];
  bit                m_plru  [15];

  tlb_alloc_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_err(resp_err), .resp_data(resp_data), .resp_way(resp_way),
    .ref_req_valid(ref_req_valid), .ref_req_ready(ref_req_ready), .ref_req_tag(ref_req_tag),
    .ref_resp_valid(ref_resp_valid), .ref_resp_err(ref_resp_err), .ref_resp_data(ref_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 15; i++) m_plru[i] = 1'b0;
  endtask

  // Tree walk: each node remembers which half was used less recently.
  task automatic plru_victim(output int w);
    int n = 0;
    for (int l = 0; l < 4; l++) n = 2 * n + 1 + (m_plru[n] ? 1 : 0);
    w = n - 15;
  endtask

  task automatic plru_touch(input int w);
    int n = 0;
    for (int lvl = 3; lvl >= 0; lvl--) begin
      int b = (w >> lvl) & 1;
      m_plru[n] = (b == 0);
      n = 2 * n + 1 + b;
    end
  endtask

  task automatic model_access(input logic [TAG_W-1:0] tag, input bit err, input logic [DATA_W-1:0] wdata,
                              input bit flush_wait, output bit e_hit, output bit e_err,
                              output logic [DATA_W-1:0] e_data, output int e_way);
    int hw = -1;
    int v = -1;
    for (int i = 0; i < 16; i++) if (m_valid[i] && m_tag[i] == tag) hw = i;
    if (hw >= 0) begin
      e_hit = 1; e_err = 0; e_data = m_data[hw]; e_way = hw;
      plru_touch(hw);
    end else begin
      e_hit = 0; e_err = err; e_data = err ? '0 : wdata; e_way = 0;
      if (flush_wait) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (!err) begin
        for (int i = 15; i >= 0; i--) if (!m_valid[i]) v = i;
        if (v < 0) plru_victim(v);
        plru_touch(v);
        m_valid[v] = 1'b1; m_tag[v] = tag; m_data[v] = wdata;
        e_way = v;
      end
    end
  endtask

  // Drives one lookup end to end; every wait is a fixed number of cycles.
  task automatic run_lookup(input logic [TAG_W-1:0] tag, input bit err, input logic [DATA_W-1:0] wdata,
                            input bit flush_wait, input int ref_dly, input int resp_dly,
                            output bit o_hit, output bit o_err, output logic [DATA_W-1:0] o_data,
                            output int o_way, output bit o_resp_seen, output bit o_miss,
                            output bit o_ref_first, output bit o_ref_held, output bit o_resp_stable);
    req_valid = 1'b1; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_miss = 0; o_ref_first = 0; o_ref_held = 1; o_resp_stable = 1;
    if (!resp_valid) begin
      o_miss = 1;
      o_ref_first = ref_req_valid && (ref_req_tag == tag);
      for (int c = 0; c < ref_dly; c++) begin
        @(posedge clk); #1;
        if (!(ref_req_valid && ref_req_tag == tag)) o_ref_held = 0;
      end
      ref_req_ready = 1'b1;
      @(posedge clk); #1;
      ref_req_ready = 1'b0;
      if (flush_wait) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      ref_resp_valid = 1'b1; ref_resp_err = err; ref_resp_data = wdata;
      @(posedge clk); #1;
      ref_resp_valid = 1'b0; ref_resp_err = 1'b0; ref_resp_data = '0;
    end
    o_resp_seen = resp_valid; o_hit = resp_hit; o_err = resp_err;
    o_data = resp_data; o_way = int'(resp_way);
    for (int c = 0; c < resp_dly; c++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_hit !== o_hit || resp_err !== o_err ||
          resp_data !== o_data || int'(resp_way) != o_way || req_ready !== 1'b0)
        o_resp_stable = 0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (ref_req_valid !== 1'b0) begin failures++; $display("FAIL reset_ref_req_valid got=%0b exp=0", ref_req_valid); end
    checks++; if ({resp_hit, resp_err, resp_way} !== 6'd0) begin failures++; $display("FAIL reset_resp_flags got=%0h exp=0", {resp_hit, resp_err, resp_way}); end
    checks++; if (resp_data !== '0 || ref_req_tag !== '0) begin failures++; $display("FAIL reset_data_tag got=%0h/%0h exp=0/0", resp_data, ref_req_tag); end
  endtask

  task automatic test_cold_misses();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    for (int i = 0; i < 16; i++) begin
      logic [TAG_W-1:0] t = TAG_W'(32'h10 + i);
      model_access(t, 0, 64'(t) + 64'h100, 0, eh, ee, ed, ew);
      run_lookup(t, 0, 64'(t) + 64'h100, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
      checks++; if (!rs || h !== 1'b0 || w != i || ew != i) begin failures++; $display("FAIL cold_miss[%0d] got seen=%0b hit=%0b way=%0d exp seen=1 hit=0 way=%0d", i, rs, h, w, i); end
      checks++; if (!rf || e !== 1'b0 || d !== ed) begin failures++; $display("FAIL cold_miss_ref[%0d] got ref_first=%0b err=%0b data=%0h exp 1/0/%0h", i, rf, e, d, ed); end
    end
  endtask

  task automatic test_hit();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    model_access(27'h13, 0, '0, 0, eh, ee, ed, ew);
    run_lookup(27'h13, 0, '0, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (!rs || ms) begin failures++; $display("FAIL hit_latency got seen=%0b via_walker=%0b exp 1/0", rs, ms); end
    checks++; if (h !== 1'b1 || w != 3 || d !== 64'h113 || eh !== 1'b1) begin failures++; $display("FAIL hit_fields got hit=%0b way=%0d data=%0h exp 1/3/113", h, w, d); end
  endtask

  task automatic test_plru_victim();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew, vway;
    for (int i = 0; i < 8; i++) begin
      logic [TAG_W-1:0] t = TAG_W'(32'h10 + i);
      model_access(t, 0, '0, 0, eh, ee, ed, ew);
      run_lookup(t, 0, '0, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
      checks++; if (h !== 1'b1 || w != i) begin failures++; $display("FAIL recency_hit[%0d] got hit=%0b way=%0d exp 1/%0d", i, h, w, i); end
    end
    model_access(27'h20, 0, 64'h120, 0, eh, ee, ed, ew);
    run_lookup(27'h20, 0, 64'h120, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    vway = w;
    checks++; if (h !== 1'b0 || w != ew || w < 8) begin failures++; $display("FAIL plru_victim got way=%0d hit=%0b exp way=%0d hit=0", w, h, ew); end
    model_access(27'h20, 0, '0, 0, eh, ee, ed, ew);
    run_lookup(27'h20, 0, '0, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (h !== 1'b1 || w != vway || d !== 64'h120) begin failures++; $display("FAIL plru_relookup got hit=%0b way=%0d data=%0h exp 1/%0d/120", h, w, d, vway); end
  endtask

  task automatic test_walker_error();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    model_access(27'h30, 1, 64'hdead, 0, eh, ee, ed, ew);
    run_lookup(27'h30, 1, 64'hdead, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (e !== 1'b1 || h !== 1'b0 || w != 0 || d !== '0) begin failures++; $display("FAIL walker_err got err=%0b hit=%0b way=%0d data=%0h exp 1/0/0/0", e, h, w, d); end
    model_access(27'h30, 0, 64'h130, 0, eh, ee, ed, ew);
    run_lookup(27'h30, 0, 64'h130, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (!ms || h !== 1'b0 || w != ew || d !== 64'h130) begin failures++; $display("FAIL err_no_fill got miss=%0b hit=%0b way=%0d exp 1/0/%0d", ms, h, w, ew); end
  endtask

  task automatic test_flush_mwait();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    model_access(27'h40, 0, 64'h140, 1, eh, ee, ed, ew);
    run_lookup(27'h40, 0, 64'h140, 1, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (!rs || h !== 1'b0 || e !== 1'b0 || d !== 64'h140) begin failures++; $display("FAIL flush_resp got seen=%0b hit=%0b err=%0b data=%0h exp 1/0/0/140", rs, h, e, d); end
    model_access(27'h13, 0, 64'h113, 0, eh, ee, ed, ew);
    run_lookup(27'h13, 0, 64'h113, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (h !== 1'b0 || w != 0) begin failures++; $display("FAIL flush_refill got hit=%0b way=%0d exp 0/0", h, w); end
    model_access(27'h40, 0, 64'h140, 0, eh, ee, ed, ew);
    run_lookup(27'h40, 0, 64'h140, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (h !== 1'b0 || w != 1) begin failures++; $display("FAIL flush_discarded got hit=%0b way=%0d exp 0/1", h, w); end
  endtask

  task automatic test_backpressure();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    model_access(27'h41, 0, 64'h141, 0, eh, ee, ed, ew);
    run_lookup(27'h41, 0, 64'h141, 0, 3, 5, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (!rf || !rh) begin failures++; $display("FAIL ref_hold got first=%0b held=%0b exp 1/1", rf, rh); end
    checks++; if (!st || d !== 64'h141 || w != ew) begin failures++; $display("FAIL miss_resp_hold got stable=%0b data=%0h way=%0d exp 1/141/%0d", st, d, w, ew); end
    model_access(27'h41, 0, '0, 0, eh, ee, ed, ew);
    run_lookup(27'h41, 0, '0, 0, 0, 5, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (!st || h !== 1'b1 || w != ew) begin failures++; $display("FAIL hit_resp_hold got stable=%0b hit=%0b way=%0d exp 1/1/%0d", st, h, w, ew); end
  endtask

  task automatic test_random();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    for (int n = 0; n < 60; n++) begin
      logic [TAG_W-1:0] t = TAG_W'(32'h50 + $urandom_range(0, 23));
      bit er = ($urandom_range(0, 7) == 0);
      bit fw = ($urandom_range(0, 11) == 0);
      logic [DATA_W-1:0] wd = {$urandom, $urandom};
      int rd = $urandom_range(0, 3);
      int pd = $urandom_range(0, 2);
      model_access(t, er, wd, fw, eh, ee, ed, ew);
      run_lookup(t, er, wd, fw, rd, pd, h, e, d, w, rs, ms, rf, rh, st);
      checks++;
      if (!rs || h !== eh || e !== ee || d !== ed || w != ew || !rh || !st) begin
        failures++;
        $display("FAIL random[%0d] tag=%0h got seen=%0b hit=%0b err=%0b data=%0h way=%0d exp hit=%0b err=%0b data=%0h way=%0d", n, t, rs, h, e, d, w, eh, ee, ed, ew);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit h, e, rs, ms, rf, rh, st, eh, ee; logic [DATA_W-1:0] d, ed; int w, ew;
    req_valid = 1'b1; req_tag = 27'h77;
    @(posedge clk); #1;
    req_valid = 1'b0; ref_req_ready = 1'b1;
    @(posedge clk); #1;
    ref_req_ready = 1'b0; rst_n = 1'b0;
    #2;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || ref_req_valid !== 1'b0) begin failures++; $display("FAIL midop_reset got resp_valid=%0b req_ready=%0b ref=%0b exp 0/1/0", resp_valid, req_ready, ref_req_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1; ref_resp_valid = 1'b1; ref_resp_data = 64'h777;
    @(posedge clk); #1;
    ref_resp_valid = 1'b0; ref_resp_data = '0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL stale_walker got resp_valid=%0b req_ready=%0b exp 0/1", resp_valid, req_ready); end
    model_reset();
    model_access(27'h77, 0, 64'h177, 0, eh, ee, ed, ew);
    run_lookup(27'h77, 0, 64'h177, 0, 0, 0, h, e, d, w, rs, ms, rf, rh, st);
    checks++; if (h !== 1'b0 || w != 0 || d !== 64'h177) begin failures++; $display("FAIL post_reset_fill got hit=%0b way=%0d data=%0h exp 0/0/177", h, w, d); end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_cold_misses();
    test_hit();
    test_plru_victim();
    test_walker_error();
    test_flush_mwait();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
